// File: rtl/cc_pkg.sv
// Shared types and helpers for the LC-3 condition-code / PSR unit.
// Frames pack privilege, priority and NZP so a single LIFO entry restores the full status.
package cc_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = NZP_Z;

  typedef struct packed {
    logic       priv;
    logic [2:0] pri;
    nzp_t       nzp;
  } psr_frame_t;

  // Callers zero-extend their bus to 64 bits and pass its real width.
  // The sign bit is picked with a shift so any width up to 64 works.
  function automatic nzp_t classify_nzp(input logic [63:0] val, input int data_w);
    logic [63:0] shifted;
    shifted = val >> (data_w - 1);
    if (val == 64'd0)
      return NZP_Z;
    else if (shifted[0])
      return NZP_N;
    else
      return NZP_P;
  endfunction

endpackage

// File: rtl/psr_stack.sv
// Bounded LIFO of PSR frames used for interrupt entry and RTI.
// Illegal requests leave the stack untouched and raise err_pulse for one cycle.
module psr_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  psr_frame_t      din,
  output psr_frame_t      dout,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output logic            err_pulse
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  psr_frame_t mem [DEPTH];
  logic       do_push;
  logic       do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~pop & ~full;
  assign do_pop    = pop & ~push & ~empty;
  assign err_pulse = (push & pop) | (push & full) | (pop & empty);
  assign dout      = mem[IW'(count - CW'(1))];

  // Storage is intentionally not reset; entries at or above count are don't-care.
  always_ff @(posedge Clk) begin
    if (do_push)
      mem[IW'(count)] <= din;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      count <= '0;
    else if (do_push)
      count <= count + CW'(1);
    else if (do_pop)
      count <= count - CW'(1);
  end

endmodule

// File: rtl/cc_psr_unit.sv
// Condition codes, branch enable and processor status for the LC-3 datapath,
// with a PSR frame stack for interrupt entry and RTI.
module cc_psr_unit
  import cc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4,
  parameter int BEN_BYPASS  = 0
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [DATA_W-1:0]                  DR_val,
  input  logic [15:0]                        IR,
  input  logic                               LD_CC,
  input  logic                               LD_BEN,
  input  logic                               Push,
  input  logic                               Pop,
  input  logic [2:0]                         Pri_In,
  input  logic                               Clr_Err,
  output logic [2:0]                         NZP_Val,
  output logic                               BEN_Val,
  output logic                               Priv,
  output logic [2:0]                         Pri,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Stack_Count,
  output logic                               Stack_Full,
  output logic                               Stack_Empty,
  output logic                               Stack_Err
);

  nzp_t       nzp_next;
  nzp_t       ben_src;
  logic       ben_next;
  logic       push_ok;
  logic       pop_ok;
  logic       err_pulse;
  psr_frame_t frame_in;
  psr_frame_t frame_top;
  logic       unused_ir;

  assign nzp_next  = classify_nzp(64'(DR_val), DATA_W);
  assign ben_src   = ((BEN_BYPASS != 0) && LD_CC) ? nzp_next : NZP_Val;
  assign ben_next  = |(IR[11:9] & ben_src);
  assign push_ok   = Push & ~Pop & ~Stack_Full;
  assign pop_ok    = Pop & ~Push & ~Stack_Empty;
  assign frame_in  = '{priv: Priv, pri: Pri, nzp: NZP_Val};
  assign unused_ir = &{1'b0, IR[15:12], IR[8:0]};

  psr_stack #(
    .DEPTH (STACK_DEPTH),
    .CW    ($clog2(STACK_DEPTH+1))
  ) u_stack (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (Push),
    .pop       (Pop),
    .din       (frame_in),
    .dout      (frame_top),
    .count     (Stack_Count),
    .full      (Stack_Full),
    .empty     (Stack_Empty),
    .err_pulse (err_pulse)
  );

  // A restored frame takes priority over a same-cycle condition-code load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      NZP_Val <= NZP_RESET;
      BEN_Val <= 1'b0;
      Priv    <= 1'b0;
      Pri     <= 3'd0;
    end else begin
      if (pop_ok)
        NZP_Val <= frame_top.nzp;
      else if (LD_CC)
        NZP_Val <= nzp_next;

      if (LD_BEN)
        BEN_Val <= ben_next;

      if (push_ok) begin
        Priv <= 1'b0;
        Pri  <= Pri_In;
      end else if (pop_ok) begin
        Priv <= frame_top.priv;
        Pri  <= frame_top.pri;
      end
    end
  end

  // A new error outranks a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (Reset)
      Stack_Err <= 1'b0;
    else if (err_pulse)
      Stack_Err <= 1'b1;
    else if (Clr_Err)
      Stack_Err <= 1'b0;
  end

endmodule
